// File: rtl/hard_mem_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbitration controller.
package hard_mem_arb_pkg;

    typedef enum logic {
        e_init,
        e_run
    } state_e;

    localparam int unsigned num_req_lp = 2;

endpackage

// File: rtl/bsg_arb_round_robin_2.sv
// Two-input round-robin arbiter. On contention the pointed-to requester wins
// and the pointer moves to the other one; an uncontested grant leaves it alone.
module bsg_arb_round_robin_2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] reqs_i,
    output logic [1:0] grants_o
);

    logic ptr_q, ptr_d;

    // Pick the winner and compute the pointer update
    always_comb begin
        grants_o = '0;
        ptr_d    = ptr_q;
        case (reqs_i)
            2'b01:   grants_o = 2'b01;
            2'b10:   grants_o = 2'b10;
            2'b11: begin
                grants_o = ptr_q ? 2'b10 : 2'b01;
                ptr_d    = ~ptr_q;
            end
            default: grants_o = '0;
        endcase
    end

    // Round-robin pointer register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/hard_mem_1rw_arb_ctrl.sv
// Controller for a 1RW hardened SRAM: zero-fills the array after reset, then
// shares the port between two requesters and returns reads through a held,
// back-pressured response register.
module hard_mem_1rw_arb_ctrl
    import hard_mem_arb_pkg::*;
#(
    parameter  int unsigned width_p       = 95,
    parameter  int unsigned els_p         = 256,
    parameter  int unsigned init_p        = 1,
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_lp-1:0]             req_v_i,
    input  logic [num_req_lp-1:0]             req_w_i,
    input  logic [num_req_lp*addr_width_lp-1:0] req_addr_i,
    input  logic [num_req_lp*width_p-1:0]     req_data_i,
    output logic [num_req_lp-1:0]             req_ready_o,
    output logic [num_req_lp-1:0]             resp_v_o,
    output logic [width_p-1:0]                resp_data_o,
    input  logic [num_req_lp-1:0]             resp_yumi_i,
    output logic                              mem_v_o,
    output logic                              mem_w_o,
    output logic [addr_width_lp-1:0]          mem_addr_o,
    output logic [width_p-1:0]                mem_data_o,
    input  logic [width_p-1:0]                mem_data_i,
    output logic                              init_done_o
);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] init_cnt_q, init_cnt_d;
    logic                     init_done_q, init_done_d;
    logic                     rd_pend_q, rd_pend_d;
    logic                     rd_id_q, rd_id_d;
    logic [num_req_lp-1:0]    resp_v_q, resp_v_d;
    logic [width_p-1:0]       resp_data_q, resp_data_d;

    logic                     read_ok;
    logic [num_req_lp-1:0]    eligible;
    logic [num_req_lp-1:0]    grants;
    logic                     gnt_id;
    logic                     gnt_w;
    logic [addr_width_lp-1:0] gnt_addr;
    logic [width_p-1:0]       gnt_data;

    // Reads need an empty response path (or one being drained); writes never wait
    always_comb begin
        read_ok  = (!rd_pend_q && (resp_v_q == '0)) || ((resp_v_q & resp_yumi_i) != '0);
        eligible = '0;
        if (state_q == e_run) begin
            eligible = req_v_i & (req_w_i | {num_req_lp{read_ok}});
        end
    end

    bsg_arb_round_robin_2 arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (eligible),
        .grants_o (grants)
    );

    // Select the winning requester's command fields
    always_comb begin
        gnt_id   = grants[1];
        gnt_w    = gnt_id ? req_w_i[1] : req_w_i[0];
        gnt_addr = gnt_id ? req_addr_i[2*addr_width_lp-1:addr_width_lp]
                          : req_addr_i[addr_width_lp-1:0];
        gnt_data = gnt_id ? req_data_i[2*width_p-1:width_p]
                          : req_data_i[width_p-1:0];
    end

    // Drive the SRAM port: zero-fill writes during INIT, granted command in RUN
    always_comb begin
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (state_q == e_init) begin
            mem_v_o    = 1'b1;
            mem_w_o    = 1'b1;
            mem_addr_o = init_cnt_q;
        end else if (grants != '0) begin
            mem_v_o    = 1'b1;
            mem_w_o    = gnt_w;
            mem_addr_o = gnt_addr;
            mem_data_o = gnt_data;
        end
    end

    // Next state: fill sequencing, read tracking and response capture/drain
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        rd_pend_d   = 1'b0;
        rd_id_d     = rd_id_q;
        resp_v_d    = resp_v_q & ~resp_yumi_i;
        resp_data_d = resp_data_q;
        case (state_q)
            e_init: begin
                if (init_cnt_q == last_addr_lp) begin
                    state_d     = e_run;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + addr_width_lp'(1);
                end
            end
            e_run: begin
                if (rd_pend_q) begin
                    resp_v_d[rd_id_q] = 1'b1;
                    resp_data_d       = mem_data_i;
                end
                if ((grants != '0) && !gnt_w) begin
                    rd_pend_d = 1'b1;
                    rd_id_d   = gnt_id;
                end
            end
            default: state_d = e_init;
        endcase
    end

    // State registers; reset aborts any fill or pending response
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= (init_p != 0) ? e_init : e_run;
            init_cnt_q  <= '0;
            init_done_q <= (init_p == 0);
            rd_pend_q   <= 1'b0;
            rd_id_q     <= 1'b0;
            resp_v_q    <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
            resp_v_q    <= resp_v_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign req_ready_o = grants;
    assign resp_v_o    = resp_v_q;
    assign resp_data_o = resp_data_q;
    assign init_done_o = init_done_q;

`ifndef SYNTHESIS
    a_yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        (resp_yumi_i & ~resp_v_q) == '0);
    a_grant_in_init: assert property (@(posedge clk_i) disable iff (reset_i)
        !((state_q == e_init) && (req_ready_o != '0)));
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(req_ready_o));
`endif

endmodule

// File: tb/tb_hard_mem_1rw_arb_ctrl.sv
// Directed bench for hard_mem_1rw_arb_ctrl with a transaction-level model.
module tb_hard_mem_1rw_arb_ctrl;

    localparam int W  = 95;
    localparam int N  = 256;
    localparam int AW = 8;

    logic            clk;
    logic            reset_i;
    logic [1:0]      req_v, req_w, req_ready, resp_v, resp_yumi;
    logic [2*AW-1:0] req_addr;
    logic [2*W-1:0]  req_data;
    logic [W-1:0]    resp_data, mem_wdata, mem_rdata;
    logic            mem_v, mem_w, init_done;
    logic [AW-1:0]   mem_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] sram    [N];
    logic [W-1:0] ref_mem [N];

    // model state
    bit           m_init;
    int           m_fill;
    bit           m_done;
    int           m_ptr;
    int           m_pend;
    int           m_pend_addr;
    logic [1:0]   m_rv;
    logic [W-1:0] m_rd;

    hard_mem_1rw_arb_ctrl #(.width_p(W), .els_p(N), .init_p(1)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_v_i     (req_v),
        .req_w_i     (req_w),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .resp_v_o    (resp_v),
        .resp_data_o (resp_data),
        .resp_yumi_i (resp_yumi),
        .mem_v_o     (mem_v),
        .mem_w_o     (mem_w),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata),
        .init_done_o (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM stub: registered read data, garbage contents before the fill
    initial begin
        for (int i = 0; i < N; i++) sram[i] = {W{1'b1}} ^ W'(i);
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_v) begin
            if (mem_w) sram[mem_addr] <= mem_wdata;
            else       mem_rdata <= sram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1;
        m_fill = 0;
        m_done = 1'b0;
        m_ptr  = 0;
        m_pend = -1;
        m_pend_addr = 0;
        m_rv   = '0;
        m_rd   = '0;
    endtask

    // Predict this cycle's outputs, compare, then apply the upcoming edge.
    task automatic model_cycle();
        bit           can_read;
        logic [1:0]   elig;
        int           g;
        logic [1:0]   e_ready;
        bit           e_mv, e_mw;
        int           e_ma;
        logic [W-1:0] e_md;
        e_ready = '0; e_mv = 0; e_mw = 0; e_ma = 0; e_md = '0; g = -1; elig = '0;
        if (m_init) begin
            e_mv = 1; e_mw = 1; e_ma = m_fill;
        end else begin
            can_read = (m_pend < 0 && m_rv == 2'b00) || ((m_rv & resp_yumi) != 2'b00);
            for (int r = 0; r < 2; r++) elig[r] = req_v[r] && (req_w[r] || can_read);
            if (elig == 2'b11)  g = m_ptr;
            else if (elig[0])   g = 0;
            else if (elig[1])   g = 1;
            if (g >= 0) begin
                e_ready[g] = 1'b1;
                e_mv = 1;
                e_mw = req_w[g];
                e_ma = int'(req_addr[g*AW +: AW]);
                e_md = req_data[g*W +: W];
            end
        end
        chk("m_ready", req_ready, e_ready);
        chk("m_mem_v", mem_v, e_mv);
        if (e_mv) begin
            chk("m_mem_w", mem_w, e_mw);
            chk("m_mem_addr", mem_addr, e_ma);
            if (e_mw) chk("m_mem_data", mem_wdata, e_md);
        end
        chk("m_resp_v", resp_v, m_rv);
        chk("m_resp_data", resp_data, m_rd);
        chk("m_init_done", init_done, m_done);

        if (m_init) begin
            ref_mem[m_fill] = '0;
            if (m_fill == N - 1) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end else begin
                m_fill++;
            end
        end else begin
            m_rv = m_rv & ~resp_yumi;
            if (m_pend >= 0) begin
                m_rv[m_pend] = 1'b1;
                m_rd = ref_mem[m_pend_addr];
                m_pend = -1;
            end
            if (g >= 0) begin
                if (req_w[g]) ref_mem[e_ma] = e_md;
                else begin
                    m_pend = g;
                    m_pend_addr = e_ma;
                end
                if (elig == 2'b11) m_ptr = 1 - m_ptr;
            end
        end
    endtask

    // Compare process: one point per cycle, just before the rising edge
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #4;
            if (reset_i) model_reset();
            else         model_cycle();
        end
    end

    task automatic idle();
        req_v = '0; req_w = '0; req_addr = '0; req_data = '0; resp_yumi = '0;
    endtask

    task automatic set_req(input int r, input bit w, input int a, input logic [W-1:0] d);
        req_v[r] = 1'b1;
        req_w[r] = w;
        req_addr[r*AW +: AW] = AW'(a);
        req_data[r*W +: W]   = d;
    endtask

    // Issue one read, wait (bounded) for its response, check it and accept it.
    task automatic do_read(input int r, input int a, input logic [W-1:0] exp, input string nm);
        int lat;
        idle();
        set_req(r, 1'b0, a, '0);
        #1;
        chk({nm, "_ready"}, req_ready, 2'b01 << r);
        lat = 0;
        do begin
            @(negedge clk);
            idle();
            #1;
            lat++;
        end while (resp_v == 2'b00 && lat < 6);
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_v"}, resp_v, 2'b01 << r);
        chk({nm, "_data"}, resp_data, exp);
        resp_yumi = resp_v;
        @(negedge clk);
        idle();
    endtask

    initial begin
        int cyc;
        idle();
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;

        // zero-fill walks every address once, then init_done rises
        for (int c = 0; c < N; c++) begin
            #1;
            chk("fill_w", {mem_v, mem_w}, 2'b11);
            chk("fill_addr", mem_addr, c);
            chk("fill_not_done", init_done, 0);
            @(negedge clk);
        end
        #1;
        chk("init_done", init_done, 1);
        chk("init_no_resp", resp_v, 0);
        @(negedge clk);

        // read of a freshly zeroed word
        do_read(0, 'h7F, '0, "t2");

        // write by r0 then read by r1
        idle();
        set_req(0, 1'b1, 'h10, W'('h3A5));
        #1;
        chk("t3_wr_ready", req_ready, 2'b01);
        @(negedge clk);
        do_read(1, 'h10, W'('h3A5), "t3_rd");

        // contested writes alternate starting with r0
        for (int i = 0; i < 6; i++) begin
            idle();
            set_req(0, 1'b1, 'h20 + i, W'('h100 + i));
            set_req(1, 1'b1, 'h40 + i, W'('h200 + i));
            #1;
            chk("t4_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
        end
        do_read(0, 'h22, W'('h102), "t4_rd0");
        do_read(1, 'h43, W'('h203), "t4_rd1");

        // held response blocks reads but not writes
        idle();
        set_req(0, 1'b0, 'h22, '0);
        #1;
        chk("t5_rd_ready", req_ready, 2'b01);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            idle();
            set_req(0, 1'b1, 'h30 + k, W'('h500 + k));
            set_req(1, 1'b0, 'h43, '0);
            #1;
            chk("t5_hold_ready", req_ready, 2'b01);
            if (k >= 1) begin
                chk("t5_hold_v", resp_v, 2'b01);
                chk("t5_hold_data", resp_data, 'h102);
            end
            @(negedge clk);
        end
        idle();
        set_req(1, 1'b0, 'h43, '0);
        resp_yumi = resp_v & 2'b01;
        #1;
        chk("t5_yumi_v", resp_v, 2'b01);
        chk("t5_yumi_ready", req_ready, 2'b10);
        @(negedge clk);
        idle();
        set_req(0, 1'b1, 'h43, W'('h777));
        #1;
        chk("t5_cap_wr_ready", req_ready, 2'b01);
        chk("t5_drained", resp_v, 2'b00);
        @(negedge clk);
        idle();
        #1;
        chk("t5_b2b_v", resp_v, 2'b10);
        chk("t5_b2b_data", resp_data, 'h203);
        resp_yumi = resp_v & 2'b10;
        @(negedge clk);
        do_read(0, 'h43, W'('h777), "t5_new");
        do_read(1, 'h34, W'('h504), "t5_wr_kept");

        // async reset with a response held, then again mid-fill
        idle();
        set_req(0, 1'b0, 'h7F, '0);
        @(negedge clk);
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t6_pre_v", resp_v, 2'b01);
        #1;
        reset_i = 1'b1;
        #1;
        chk("t6_async_v", resp_v, 0);
        chk("t6_async_data", resp_data, 0);
        chk("t6_async_init", {mem_v, mem_w}, 2'b11);
        chk("t6_async_addr", mem_addr, 0);
        chk("t6_async_done", init_done, 0);
        @(negedge clk);
        reset_i = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        chk("t6_addr100", mem_addr, 100);
        #1;
        reset_i = 1'b1;
        #1;
        chk("t6_abort_addr", mem_addr, 0);
        chk("t6_abort_done", init_done, 0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("t6_restart", mem_addr, 0);
        cyc = 0;
        while (!init_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        chk("t6_refill_cycles", cyc, 256);
        do_read(0, 'h22, '0, "t6_zeroed");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
